// File: rtl/buffer_reader_if.sv
// Buffer/consumer bundle for buffer_reader: write pointer, stall strobe,
// read data/address towards the UART buffer and the character handshake
// towards the Morse encoder. The master modport is the reader's view.
interface buffer_reader_if;
    logic [10:0] i_wr_addr;
    logic        i_wr_busy;
    logic [6:0]  i_rd_data;
    logic        i_ready;
    logic [10:0] o_rd_addr;
    logic [6:0]  o_char;
    logic        o_valid;
    logic        o_empty;
    logic [10:0] o_count;

    modport master (
        input  i_wr_addr, i_wr_busy, i_rd_data, i_ready,
        output o_rd_addr, o_char, o_valid, o_empty, o_count
    );

    modport slave (
        output i_wr_addr, i_wr_busy, i_rd_data, i_ready,
        input  o_rd_addr, o_char, o_valid, o_empty, o_count
    );
endinterface

// File: rtl/buffer_reader.sv
// buffer_reader: drains a 2048-entry character buffer one entry at a time
// and hands each character to a consumer with a valid/ready handshake.
// Optional macro BUFFER_READER_FILTER_EN: control codes (< 0x20 or 0x7F)
// are skipped instead of being presented.
module buffer_reader #(
    parameter int RD_LATENCY = 3
) (
    input  logic           i_clk_24,
    input  logic           i_rst_n,
    buffer_reader_if.master bus
);

    localparam int CW = $clog2(RD_LATENCY + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t        state;
    state_t        state_next;
    logic [10:0]   rd_ptr;
    logic [CW-1:0] lat_cnt;
    logic [6:0]    char_q;
    logic          fetch_done;
    logic          drop;
    logic          accept;
    logic          is_ctrl;

    // Control strobes: the fetch completes on the RD_LATENCY-th clean
    // FETCH cycle, so accepted characters are RD_LATENCY + 2 cycles apart.
    always_comb begin
        fetch_done = (state == FETCH) && !bus.i_wr_busy && (lat_cnt == LAST_CNT);
        is_ctrl    = (bus.i_rd_data < 7'h20) || (bus.i_rd_data == 7'h7F);
`ifdef BUFFER_READER_FILTER_EN
        drop       = fetch_done && is_ctrl;
`else
        drop       = 1'b0;
`endif
        accept     = (state == PRESENT) && bus.i_ready;
    end

    // State register.
    always_ff @(posedge i_clk_24 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (rd_ptr != bus.i_wr_addr) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (fetch_done) begin
                    state_next = drop ? IDLE : PRESENT;
                end
            end
            PRESENT: begin
                if (bus.i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latency counter, read pointer and captured character.
    always_ff @(posedge i_clk_24 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lat_cnt <= '0;
            rd_ptr  <= '0;
            char_q  <= '0;
        end else begin
            if (state != FETCH || bus.i_wr_busy) begin
                lat_cnt <= '0;
            end else if (!fetch_done) begin
                lat_cnt <= lat_cnt + CW'(1);
            end
            if (accept || drop) begin
                rd_ptr <= rd_ptr + 11'd1;
            end
            if (fetch_done && !drop) begin
                char_q <= bus.i_rd_data;
            end
        end
    end

    // Outputs: valid follows the PRESENT state, occupancy is combinational.
    always_comb begin
        bus.o_rd_addr = rd_ptr;
        bus.o_char    = char_q;
        bus.o_valid   = (state == PRESENT);
        bus.o_empty   = (rd_ptr == bus.i_wr_addr);
        bus.o_count   = bus.i_wr_addr - rd_ptr;
    end

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 Parameter RD_LATENCY, default 3, clocks from a stable o_rd_addr until i_rd_data is valid.
REQ-002 i_clk_24  input  1  24 MHz system clock; all state changes on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_wr_addr  input  11  next write address from the UART buffer (write pointer).
REQ-005 i_wr_busy  input  1  buffer write strobe, HI on any cycle the buffer is writing.
REQ-006 i_rd_data  input  7  buffer data at o_rd_addr.
REQ-007 i_ready  input  1  consumer (Morse encoder) accepts o_char this cycle.
REQ-008 o_rd_addr  output  11  read address to buffer; equals internal read pointer at all times.
REQ-009 o_char  output  7  character presented to consumer.
REQ-010 o_valid  output  1  o_char valid; held until accepted.
REQ-011 o_empty  output  1  HI when read pointer == i_wr_addr.
REQ-012 o_count  output  11  unread entries = (i_wr_addr - read pointer) mod 2048, combinational.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, PRESENT, with registered state.
REQ-014 IDLE: if o_empty LO, go to FETCH and clear the latency counter; else stay.
REQ-015 FETCH: latency counter increments each cycle i_wr_busy is LO; i_wr_busy HI clears it to 0 (buffer read path stalls during writes).
REQ-016 FETCH: once the counter reaches RD_LATENCY, capture i_rd_data into o_char, set o_valid, go to PRESENT.
REQ-017 PRESENT: o_char and o_valid SHALL stay stable until i_ready is HI.
REQ-018 PRESENT with i_ready HI: read pointer += 1 (wraps 2047 -> 0), o_valid LO next cycle, go to IDLE.
REQ-019 Minimum spacing between accepted characters SHALL be RD_LATENCY + 2 cycles.
REQ-020 Pointer arithmetic SHALL be 11-bit modulo 2048; o_empty SHALL compare full 11 bits, so 2048 unread entries is indistinguishable from empty (writer's responsibility).
REQ-021 i_ready while o_valid is LO SHALL be ignored.
REQ-022 i_wr_addr change during FETCH or PRESENT SHALL NOT disturb the in-flight character.

Reset
REQ-023 On i_rst_n LO, immediately: state IDLE, read pointer 0, o_rd_addr 0, o_char 0, o_valid 0, latency counter 0.
REQ-024 Reset mid-FETCH or mid-PRESENT SHALL discard the character without advancing the pointer.
REQ-025 After deassertion, o_empty SHALL reflect i_wr_addr == 0 on the first cycle.

Configuration
REQ-026 Macro BUFFER_READER_FILTER_EN SHALL gate control-character filtering.
REQ-027 With BUFFER_READER_FILTER_EN defined: at the end of FETCH, data < 7'h20 or == 7'h7F SHALL NOT be presented; pointer += 1 and FSM returns to IDLE, o_valid stays LO.
REQ-028 Without it: every byte, including control codes, SHALL be presented as in REQ-016.

Verification
REQ-029 Reset, i_wr_addr=0 -> o_empty=1, o_valid=0, o_rd_addr=0, o_count=0 indefinitely.
REQ-030 Buffer holds 'S'(7'h53) at 0, i_wr_addr=1, i_ready=1 -> o_valid HI for 1 cycle with o_char=7'h53, RD_LATENCY+1 cycles after leaving IDLE; then o_rd_addr=1, o_empty=1.
REQ-031 Read pointer 2047, i_wr_addr=1, data 'A','B' -> 'A' then 'B' delivered, o_rd_addr wraps 2047 -> 0 -> 1, o_count 2 -> 1 -> 0.
REQ-032 i_ready LO for 50 cycles in PRESENT -> o_char/o_valid unchanged, o_rd_addr unchanged; i_ready HI -> pointer advances exactly once.
REQ-033 i_wr_busy HI in 2nd FETCH cycle -> capture delayed to RD_LATENCY clean cycles after busy drops; o_char correct.
REQ-034 FILTER_EN defined, buffer 7'h0A,7'h45 -> only 7'h45 presented, o_rd_addr ends at 2; undefined -> both presented in order.
